// File: rtl/pasta_rej_sampler_if.sv
// Handshake bundle between the rejection sampler, its job controller,
// the Grain LFSR word source and the downstream element consumer.
// Both streams use a valid/ready-style handshake:
//   rnd_*  : rnd_req_o is a level request; the source answers with a
//            one-cycle rnd_valid_i pulse carrying rnd_data_i.
//   elem_* : a word moves on every cycle where elem_valid_o and
//            elem_ready_i are both high; elem_data_o holds steady while
//            elem_valid_o is high and elem_ready_i is low.
interface pasta_rej_sampler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ELEM_WIDTH = 17
);
    logic                  start_i;
    logic [15:0]           count_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  rnd_req_o;
    logic                  rnd_valid_i;
    logic [DATA_WIDTH-1:0] rnd_data_i;
    logic                  elem_valid_o;
    logic                  elem_ready_i;
    logic [ELEM_WIDTH-1:0] elem_data_o;
    logic [15:0]           reject_cnt_o;

    // Sampler side
    modport slave (
        input  start_i, count_i, rnd_valid_i, rnd_data_i, elem_ready_i,
        output busy_o, done_o, rnd_req_o, elem_valid_o, elem_data_o, reject_cnt_o
    );

    // Controller / source / consumer side
    modport master (
        output start_i, count_i, rnd_valid_i, rnd_data_i, elem_ready_i,
        input  busy_o, done_o, rnd_req_o, elem_valid_o, elem_data_o, reject_cnt_o
    );
endinterface

// File: rtl/pasta_rej_sampler.sv
// Rejection sampler: converts raw LFSR words into uniform elements mod
// MODULUS (keep the low ELEM_WIDTH bits if below MODULUS, drop otherwise)
// and delivers exactly count_i accepted elements per job through a small
// output FIFO. Only one random word is ever requested at a time, and a
// request is raised only when the FIFO has room, so the FIFO cannot overflow.
module pasta_rej_sampler #(
    parameter int DATA_WIDTH = 32,
    parameter int ELEM_WIDTH = 17,
    parameter int MODULUS    = 65537,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pasta_rej_sampler_if.slave   bus,
    output logic [1:0]           dbg_state_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [ELEM_WIDTH:0] MOD_V   = MODULUS[ELEM_WIDTH:0];
    localparam logic [OCC_W-1:0]    DEPTH_V = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [15:0]           r_count;
    logic [15:0]           r_accepted;
    logic [15:0]           r_reject;
    logic                  r_req;
    logic                  r_done;
    logic [ELEM_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;

    logic [ELEM_WIDTH-1:0] w_cand;
    logic                  w_sample;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_start_job;
    logic                  w_start_zero;
    logic                  w_unused_bits;

    // Upper word bits carry no information for the candidate.
    assign w_unused_bits = ^bus.rnd_data_i[DATA_WIDTH-1:ELEM_WIDTH];

    assign w_cand       = bus.rnd_data_i[ELEM_WIDTH-1:0];
    // A word counts only if it answers our outstanding request during RUN.
    assign w_sample     = bus.rnd_valid_i & r_req & (r_state == S_RUN);
    assign w_accept     = w_sample & ({1'b0, w_cand} < MOD_V);
    assign w_reject     = w_sample & ~({1'b0, w_cand} < MOD_V);
    assign w_empty      = (r_occ == '0);
    assign w_pop        = ~w_empty & bus.elem_ready_i;
    assign w_start_job  = (r_state == S_IDLE) & bus.start_i & (bus.count_i != 16'd0);
    assign w_start_zero = (r_state == S_IDLE) & bus.start_i & (bus.count_i == 16'd0);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic: RUN ends on the push that completes the job,
    // FLUSH ends once the consumer has drained the FIFO.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_job) w_next_state = S_RUN;
            S_RUN:   if (w_accept && (r_accepted + 16'd1 == r_count)) w_next_state = S_FLUSH;
            S_FLUSH: if (w_empty) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Job counters: latch target on start, count accepts and saturating rejects.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count    <= 16'd0;
            r_accepted <= 16'd0;
            r_reject   <= 16'd0;
        end else if (w_start_job) begin
            r_count    <= bus.count_i;
            r_accepted <= 16'd0;
            r_reject   <= 16'd0;
        end else begin
            if (w_accept) r_accepted <= r_accepted + 16'd1;
            if (w_reject && (r_reject != 16'hFFFF)) r_reject <= r_reject + 16'd1;
        end
    end

    // Request: hold until answered, then at least one low cycle before re-arming.
    always_ff @(posedge clk_i) begin
        if (rst_i)      r_req <= 1'b0;
        else if (r_req) r_req <= ~bus.rnd_valid_i;
        else            r_req <= (r_state == S_RUN) && (r_accepted < r_count) && (r_occ < DEPTH_V);
    end

    // Done pulse, one cycle after the job ends (or after a zero-length start).
    always_ff @(posedge clk_i) begin
        if (rst_i) r_done <= 1'b0;
        else       r_done <= ((r_state == S_FLUSH) && w_empty) || w_start_zero;
    end

    // FIFO pointers and occupancy; push and pop in one cycle keep occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (w_accept) r_mem[r_wr_ptr] <= w_cand;
    end

    assign bus.busy_o       = (r_state != S_IDLE);
    assign bus.done_o       = r_done;
    assign bus.rnd_req_o    = r_req;
    assign bus.elem_valid_o = ~w_empty;
    assign bus.elem_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.reject_cnt_o = r_reject;
    assign dbg_state_o      = r_state;
endmodule
